// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with built-in baud-tick generator.
// Delivers one word per frame on a single-cycle done pulse, with framing-error flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     dvsr,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            busy
);

  // Tick counter must reach SB_TICK-1 as well as the 16-tick data bit.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  logic            rx_meta_q, rx_s_q;
  logic [10:0]     cnt_q, cnt_d;
  logic            tick;
  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            done_q, done_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The >= compare keeps a mid-count shrink of dvsr from wrapping through 2048.
  always_comb begin
    tick  = (cnt_q >= dvsr);
    cnt_d = tick ? '0 : cnt_q + 11'd1;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = ferr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames and checks captured words
// against hand-computed values.
module tb_uart_rx;

  logic        clk;
  logic        reset;
  logic [10:0] dvsr;
  logic        rx;
  logic        rx_done_tick;
  logic [7:0]  dout;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int rd       = 0;
  logic [7:0] dq[$];
  logic       fq[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .dvsr         (dvsr),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      dq.push_back(dout);
      fq.push_back(frame_err);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int unsigned cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // stop_len shorter than per leaves the line high again before the FSM returns to idle.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit,
                           input int unsigned per, input int unsigned stop_len);
    rx = 1'b0;
    idle(per);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = data[i];
      idle(per);
    end
    rx = stop_bit;
    idle(stop_len);
    rx = 1'b1;
    idle(per - stop_len);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic f);
    if (rd < dq.size()) begin
      check_eq({tag, "_dout"}, 32'(dq[rd]), 32'(d));
      check_eq({tag, "_ferr"}, 32'(fq[rd]), 32'(f));
    end else begin
      check_eq({tag, "_present"}, 32'(dq.size()), 32'(rd + 1));
    end
    rd++;
  endtask

  initial begin : stim
    logic seen_busy;
    reset = 1'b0;
    rx    = 1'b1;
    dvsr  = 11'd3;
    idle(3);
    check_eq("rst_done", 32'(rx_done_tick), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(20);

    // 1: basic frame
    send_byte(8'h55, 1'b1, 64, 64);
    idle(40);
    check_eq("t1_pulses", 32'(dq.size()), 32'd1);
    expect_frame("t1", 8'h55, 1'b0);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // 2: back-to-back
    send_byte(8'hA3, 1'b1, 64, 64);
    send_byte(8'h0F, 1'b1, 64, 64);
    idle(40);
    check_eq("t2_pulses", 32'(dq.size()), 32'd3);
    expect_frame("t2a", 8'hA3, 1'b0);
    expect_frame("t2b", 8'h0F, 1'b0);

    // 3: short glitch rejected
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    check_eq("t3_busy_seen", 32'(seen_busy), 32'd1);
    check_eq("t3_busy_end", 32'(busy), 32'd0);
    check_eq("t3_pulses", 32'(dq.size()), 32'd3);
    check_eq("t3_dout", 32'(dout), 32'h0F);

    // 4: framing error then good frame
    send_byte(8'h81, 1'b0, 64, 40);
    idle(64);
    send_byte(8'h7E, 1'b1, 64, 64);
    idle(40);
    check_eq("t4_pulses", 32'(dq.size()), 32'd5);
    expect_frame("t4a", 8'h81, 1'b1);
    expect_frame("t4b", 8'h7E, 1'b0);

    // 5: async reset during data bit 4
    fork
      send_byte(8'hFF, 1'b1, 64, 64);
      begin
        idle(352);
        reset = 1'b0;
        #1;
        check_eq("t5_rst_dout", 32'(dout), 32'h00);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_done", 32'(rx_done_tick), 32'd0);
        check_eq("t5_rst_ferr", 32'(frame_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
      end
    join
    idle(40);
    check_eq("t5_no_pulse", 32'(dq.size()), 32'd5);
    check_eq("t5_dout_held", 32'(dout), 32'h00);
    send_byte(8'h3C, 1'b1, 64, 64);
    idle(40);
    check_eq("t5_pulses", 32'(dq.size()), 32'd6);
    expect_frame("t5", 8'h3C, 1'b0);

    // 6: baud tolerance and dvsr=0
    send_byte(8'hC6, 1'b1, 62, 62);
    idle(64);
    send_byte(8'hC6, 1'b1, 66, 66);
    idle(64);
    dvsr = 11'd0;
    idle(8);
    send_byte(8'h5A, 1'b1, 16, 16);
    idle(40);
    check_eq("t6_pulses", 32'(dq.size()), 32'd9);
    expect_frame("t6_fast", 8'hC6, 1'b0);
    expect_frame("t6_slow", 8'hC6, 1'b0);
    expect_frame("t6_dvsr0", 8'h5A, 1'b0);
    check_eq("t6_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
